// File: rtl/pad_gpio_ctrl.sv
// pad_gpio_ctrl: per-pad GPIO control stage in front of the bidirectional pad cell.
// Registers the core's drive value, output enable and attributes toward the pad.
// Synchronizes and glitch-filters the received pad value, then detects edges.
// Filtered edges feed a sticky interrupt pending bit.
// Optional feature macro: PAD_GPIO_FILTER_EN.
//   When defined, a programmable glitch filter of length filt_len_i is built.
//   When undefined, the filter collapses to a plain follower (behaves as N=0)
//   and filt_len_i is ignored.
module pad_gpio_ctrl #(
  parameter int PADATTR = 16,
  parameter int FILT_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               out_val_i,
  input  logic               oe_i,
  input  logic [PADATTR-1:0] attr_i,
  input  logic [FILT_W-1:0]  filt_len_i,
  input  logic               irq_rise_en_i,
  input  logic               irq_fall_en_i,
  input  logic               irq_clr_i,
  output logic               pad_in_o,
  output logic               pad_oe_o,
  output logic [PADATTR-1:0] pad_attributes_o,
  input  logic               pad_out_i,
  output logic               in_val_o,
  output logic               rise_o,
  output logic               fall_o,
  output logic               irq_o
);

  logic sync1;
  logic sync2;
  logic stb;
  logic update;
  logic irq_set;

  // Output path: straight registered copy of the core's pad controls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pad_in_o         <= 1'b0;
      pad_oe_o         <= 1'b0;
      pad_attributes_o <= '0;
    end else begin
      pad_in_o         <= out_val_i;
      pad_oe_o         <= oe_i;
      pad_attributes_o <= attr_i;
    end
  end

  // Two-flop synchronizer for the asynchronous value received from the pad.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pad_out_i;
      sync2 <= sync1;
    end
  end

`ifdef PAD_GPIO_FILTER_EN
  logic [FILT_W-1:0] cnt;

  // Accept the new level once it has differed from stb for more than N cycles;
  // >= keeps a lowered filt_len_i from stranding a count above the new limit.
  always_comb begin
    update = (sync2 != stb) && (cnt >= filt_len_i);
  end

  // Filter counter: restarts whenever the input agrees with stb or on an update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if ((sync2 == stb) || update) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_filt_len;

  // Without the filter every difference is accepted on the next compare.
  always_comb begin
    update          = (sync2 != stb);
    unused_filt_len = ^filt_len_i;
  end
`endif

  // Stable value and one-cycle edge pulses, both produced on the update event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stb    <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      if (update) begin
        stb <= sync2;
      end
      rise_o <= update & sync2;
      fall_o <= update & ~sync2;
    end
  end

  assign in_val_o = stb;

  // Enabled edge pulses set the pending bit.
  always_comb begin
    irq_set = (rise_o & irq_rise_en_i) | (fall_o & irq_fall_en_i);
  end

  // Sticky pending bit; a coincident set beats the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else if (irq_set) begin
      irq_o <= 1'b1;
    end else if (irq_clr_i) begin
      irq_o <= 1'b0;
    end
  end

endmodule
